acq_search_scheduler: RTL and testbench
=======================================

# acq_search_scheduler

Sequencer for the acquisition search over the single tracking correlator channel. On a start command it sweeps a satellite range and a grid of carrier-frequency bins and retunes the channel's `satellite_id` / `carr_frequency` for each cell. For each cell it non-coherently accumulates prompt-arm energy over a programmable number of integration dumps and stops at the first cell whose energy exceeds the acquisition threshold. It sits between the Wishbone register file, which supplies configuration and reads the result, and the correlator/NCO datapath.

## Interface
Parameters:
- `ACC_W`, 24: energy accumulator width. Must be ≥ 24 (8 dumps × 2^21).

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle search command. Ignored while `busy`=1.
- `abort` in 1: stop the search. Has priority over every other input.
- `sat_first`, `sat_last` in 5: satellite range. Satellites are visited in increasing order, modulo 32.
- `carr_freq_base` in 30: carrier word for bin 0.
- `carr_freq_step` in 30: per-bin increment. Two's complement; the sum wraps modulo 2^30.
- `num_bins` in 6: bins per satellite. 0 is treated as 1.
- `dwell` in 3: dumps accumulated per cell. 0 means 8.
- `acq_threshold` in 15: detection threshold.
- `dump_valid` in 1: one-cycle strobe from the correlator. Dump data is valid in that cycle.
- `prompt_idata`, `prompt_qdata` in 20: signed prompt correlator outputs.
- `satellite_id` out 5: PRN select to the code generator.
- `carr_frequency` out 30: carrier NCO word.
- `chan_restart` out 1: one-cycle pulse that restarts the correlator after a retune.
- `busy` out 1: high from the start edge until `done` or abort.
- `done` out 1: one-cycle pulse at search completion.
- `found` out 1: the completed search detected a cell.
- `found_sat` out 5, `found_bin` out 6, `found_energy` out ACC_W: detected cell and its energy.

## Operation
- States: IDLE, TUNE, SETTLE, DWELL, EVAL, FINISH.
- **IDLE**
  - On `start`: load `sat_first` into `satellite_id` and `carr_freq_base` into `carr_frequency`.
  - Set bin=0, busy=1, clear `found`/`found_*`, latch `sat_last`, `num_bins`, `dwell` and `acq_threshold`, then go to TUNE.
- **TUNE**: one cycle, `chan_restart`=1, clear the accumulator and dump counter, go to SETTLE.
- **SETTLE**: wait for `dump_valid`. That dump straddles the retune, so discard it and go to DWELL.
- **DWELL**
  - On each `dump_valid`: acc += |I| + |Q|. Magnitudes are 20-bit unsigned (|−2^19| = 2^19), so the sum is 21 bits.
  - After the `dwell`-th counted dump, go to EVAL. The accumulator cannot overflow, so no saturation logic is needed.
- **EVAL**: one cycle.
  - Detection if acc > {acq_threshold, 9'b0} (unsigned, ACC_W bits). Equality is not a detection.
  - On detection: `found`=1, `found_sat`=`satellite_id`, `found_bin`=bin, `found_energy`=acc, go to FINISH.
  - Else if bin < latched num_bins−1: bin+1, `carr_frequency` += step, go to TUNE.
  - Else if `satellite_id` == latched sat_last: go to FINISH with `found`=0.
  - Else: `satellite_id`+1 (mod 32), bin=0, `carr_frequency`=`carr_freq_base`, go to TUNE.
- **FINISH**: `done`=1 and `busy`=0 registered for one cycle, then IDLE. `satellite_id` and `carr_frequency` hold the last cell, so a detected cell stays tuned for tracking hand-off.
- `dump_valid` is ignored in IDLE, TUNE, EVAL and FINISH.
- **Abort** in any state: IDLE on the next edge. busy=0, no `done`, no `chan_restart`. `found*` keep their cleared values, and the tuning outputs hold.
- `start` and `abort` in the same cycle: abort wins and the state stays IDLE.
- `start` while busy: no effect on state, counters or outputs.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `satellite_id`=0, `carr_frequency`=0, `chan_restart`=0, `busy`=0, `done`=0, `found`=0, `found_sat`=0, `found_bin`=0, `found_energy`=0.
- Reset mid-search returns to these values on the next edge. No `done` pulse is produced.
- Start at edge N: `busy`, `satellite_id` and `carr_frequency` update at N+1, and `chan_restart` is high for cycle N+1.
- Each cell costs 1 (TUNE) + dwell+1 dumps + 1 (EVAL) cycles.
- The last dump edge D gives EVAL at D+1. The outputs for the next cell, or `done`, appear at D+2.
- Worst case: 32 sats × 63 bins × 9 dumps.

## Test plan
- **Detect on first cell:** sat_first=3, sat_last=5, num_bins=4, dwell=2, threshold=1; feed I=1000, Q=−1000 each dump. Expect found=1, found_sat=3, found_bin=0, found_energy=4000, one `done` pulse, and exactly one `chan_restart`.
- **Full sweep with no detection:** sats 30→1 (wraps through 31, 0), num_bins=3, base=0x100, step=−0x10, threshold max, I=Q=0. Expect satellite sequence 30, 31, 0, 1 and carr_frequency 0x100, 0xF0, 0xE0 per satellite; 12 `chan_restart` pulses; `done` with found=0; outputs left at sat 1 / 0xE0.
- **Settle discard and threshold boundary:** dwell=1, first dump per cell large, second dump with acc exactly {thr,9'b0}. Expect no detection. Make the second dump one higher: expect detection.
- **Extreme inputs:** I=Q=−2^19, dwell=0. Expect 8 dumps accumulated and found_energy=0x800000.
- **Abort and reset mid-search:** abort during DWELL → busy=0 next cycle, no `done`. Start with abort in the same cycle → stays IDLE. Assert wb_rst_i=0 mid-DWELL → all outputs at reset values.
- **Start while busy:** pulse `start` during SETTLE. Sequence and outputs are unchanged.

Source files
------------

// File: rtl/acq_search_scheduler.sv
// Acquisition search sequencer: sweeps satellites x carrier bins, accumulates prompt energy, stops on first hit.
// Latency: retune outputs one cycle after start; per cell 1 (tune) + dwell+1 dumps + 1 (eval) cycles.
// Backpressure: none; dumps are consumed as they arrive, start is ignored while busy, abort wins over everything.
module acq_search_scheduler #(
  parameter int ACC_W = 24
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        sat_first,
  input  logic [4:0]        sat_last,
  input  logic [29:0]       carr_freq_base,
  input  logic [29:0]       carr_freq_step,
  input  logic [5:0]        num_bins,
  input  logic [2:0]        dwell,
  input  logic [14:0]       acq_threshold,
  input  logic              dump_valid,
  input  logic [19:0]       prompt_idata,
  input  logic [19:0]       prompt_qdata,
  output logic [4:0]        satellite_id,
  output logic [29:0]       carr_frequency,
  output logic              chan_restart,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [4:0]        found_sat,
  output logic [5:0]        found_bin,
  output logic [ACC_W-1:0]  found_energy
);

  typedef enum logic [2:0] {
    S_IDLE, S_TUNE, S_SETTLE, S_DWELL, S_EVAL, S_FINISH
  } state_t;

  state_t            state;
  logic [5:0]        bin;
  logic [ACC_W-1:0]  acc;
  logic [3:0]        dump_cnt;
  logic [4:0]        lat_sat_last;
  logic [5:0]        lat_bins_m1;
  logic [3:0]        lat_dwell;
  logic [14:0]       lat_thr;

  logic [20:0]       dump_mag;
  logic [ACC_W-1:0]  thr_ext;
  logic [ACC_W-1:0]  acc_next;

  // Two's complement magnitude; -2^19 maps to 2^19, which still fits 20 unsigned bits.
  function automatic logic [19:0] mag20(input logic [19:0] v);
    return v[19] ? (~v + 20'd1) : v;
  endfunction

  // Energy of the current dump and the threshold scaled into accumulator units.
  always_comb begin
    dump_mag = {1'b0, mag20(prompt_idata)} + {1'b0, mag20(prompt_qdata)};
    thr_ext  = ACC_W'({lat_thr, 9'b0});
    acc_next = acc + ACC_W'(dump_mag);
  end

  // Search sequencer: state, cell counters, accumulator and all registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state          <= S_IDLE;
      bin            <= '0;
      acc            <= '0;
      dump_cnt       <= '0;
      lat_sat_last   <= '0;
      lat_bins_m1    <= '0;
      lat_dwell      <= '0;
      lat_thr        <= '0;
      satellite_id   <= '0;
      carr_frequency <= '0;
      chan_restart   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      found_sat      <= '0;
      found_bin      <= '0;
      found_energy   <= '0;
    end else if (abort) begin
      // Tuning and result registers hold; only the control flags drop.
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      chan_restart <= 1'b0;
    end else begin
      chan_restart <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            satellite_id   <= sat_first;
            carr_frequency <= carr_freq_base;
            bin            <= '0;
            busy           <= 1'b1;
            found          <= 1'b0;
            found_sat      <= '0;
            found_bin      <= '0;
            found_energy   <= '0;
            lat_sat_last   <= sat_last;
            lat_bins_m1    <= (num_bins == 6'd0) ? 6'd0 : num_bins - 6'd1;
            lat_dwell      <= (dwell == 3'd0) ? 4'd8 : {1'b0, dwell};
            lat_thr        <= acq_threshold;
            chan_restart   <= 1'b1;
            state          <= S_TUNE;
          end
        end
        S_TUNE: begin
          acc      <= '0;
          dump_cnt <= '0;
          state    <= S_SETTLE;
        end
        S_SETTLE: begin
          // This dump integrated across the retune, so it carries no usable energy.
          if (dump_valid) state <= S_DWELL;
        end
        S_DWELL: begin
          if (dump_valid) begin
            acc      <= acc_next;
            dump_cnt <= dump_cnt + 4'd1;
            if (dump_cnt + 4'd1 == lat_dwell) state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (acc > thr_ext) begin
            found        <= 1'b1;
            found_sat    <= satellite_id;
            found_bin    <= bin;
            found_energy <= acc;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= S_FINISH;
          end else if (bin < lat_bins_m1) begin
            bin            <= bin + 6'd1;
            carr_frequency <= carr_frequency + carr_freq_step;
            chan_restart   <= 1'b1;
            state          <= S_TUNE;
          end else if (satellite_id == lat_sat_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FINISH;
          end else begin
            satellite_id   <= satellite_id + 5'd1;
            bin            <= '0;
            carr_frequency <= carr_freq_base;
            chan_restart   <= 1'b1;
            state          <= S_TUNE;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_search_scheduler.sv
// Directed bench for acq_search_scheduler with a cell-sweep model and per-event scoreboard.
// Latency: checks restart timing one cycle after start and done two cycles after the last dump.
// Backpressure: dumps are paced every third cycle after each observed retune.
module tb_acq_search_scheduler;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        start, abort;
  logic [4:0]  sat_first, sat_last;
  logic [29:0] carr_freq_base, carr_freq_step;
  logic [5:0]  num_bins;
  logic [2:0]  dwell;
  logic [14:0] acq_threshold;
  logic        dump_valid;
  logic [19:0] prompt_idata, prompt_qdata;
  logic [4:0]  satellite_id;
  logic [29:0] carr_frequency;
  logic        chan_restart, busy, done, found;
  logic [4:0]  found_sat;
  logic [5:0]  found_bin;
  logic [23:0] found_energy;

  acq_search_scheduler #(.ACC_W(24)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .sat_first(sat_first), .sat_last(sat_last),
    .carr_freq_base(carr_freq_base), .carr_freq_step(carr_freq_step),
    .num_bins(num_bins), .dwell(dwell), .acq_threshold(acq_threshold),
    .dump_valid(dump_valid), .prompt_idata(prompt_idata), .prompt_qdata(prompt_qdata),
    .satellite_id(satellite_id), .carr_frequency(carr_frequency),
    .chan_restart(chan_restart), .busy(busy), .done(done), .found(found),
    .found_sat(found_sat), .found_bin(found_bin), .found_energy(found_energy)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Search configuration as the model sees it.
  logic [4:0]  c_sat_first, c_sat_last;
  logic [29:0] c_base, c_step;
  logic [5:0]  c_bins;
  logic [2:0]  c_dwell;
  logic [14:0] c_thr;

  // Dump stimulus: index 0 is the settle dump, 1.. are counted dumps.
  int di [0:8];
  int dq [0:8];
  int hit_cell = -1;
  int hit_i = 0;
  int hit_q = 0;

  function automatic int stim_i(input int c, input int k);
    if (k == 0) return di[0];
    if (c == hit_cell) return hit_i;
    return di[k];
  endfunction

  function automatic int stim_q(input int c, input int k);
    if (k == 0) return dq[0];
    if (c == hit_cell) return hit_q;
    return dq[k];
  endfunction

  function automatic longint magn(input int v);
    return (v < 0) ? -longint'(v) : longint'(v);
  endfunction

  typedef struct packed { logic [4:0] sat; logic [29:0] freq; } cell_t;
  cell_t       exp_q[$];
  logic        m_found;
  logic [4:0]  m_sat, m_last_sat;
  logic [5:0]  m_bin;
  logic [23:0] m_energy;
  logic [29:0] m_last_freq;
  int          m_cells;

  // Walk the search grid in visiting order and stop at the first cell beating the threshold.
  function automatic void build_model();
    int nb, d, s, c;
    logic [29:0] f;
    longint e;
    nb = (c_bins == 6'd0) ? 1 : int'(c_bins);
    d  = (c_dwell == 3'd0) ? 8 : int'(c_dwell);
    s  = int'(c_sat_first);
    c  = 0;
    exp_q.delete();
    m_found = 1'b0; m_sat = '0; m_bin = '0; m_energy = '0; m_cells = 0;
    for (int n = 0; n < 32; n++) begin
      for (int b = 0; b < nb; b++) begin
        f = c_base + 30'(b) * c_step;
        exp_q.push_back('{sat: 5'(s), freq: f});
        m_last_sat = 5'(s);
        m_last_freq = f;
        e = 0;
        for (int k = 1; k <= d; k++) e += magn(stim_i(c, k)) + magn(stim_q(c, k));
        c++;
        m_cells = c;
        if (e > longint'(c_thr) * 512) begin
          m_found = 1'b1; m_sat = 5'(s); m_bin = 6'(b); m_energy = 24'(e);
          return;
        end
      end
      if (s == int'(c_sat_last)) return;
      s = (s + 1) % 32;
    end
  endfunction

  int n_restart = 0;
  int n_done = 0;
  int drv_cell = -1;
  int drv_k = 0;
  int drv_cnt = 0;

  // Correlator stand-in: one dump every third cycle after each retune while the search runs.
  initial begin
    dump_valid = 1'b0; prompt_idata = '0; prompt_qdata = '0;
    forever begin
      @(negedge wb_clk_i);
      dump_valid = 1'b0;
      if (chan_restart) begin
        drv_cell++; drv_k = 0; drv_cnt = 0;
      end else if (busy) begin
        drv_cnt++;
        if (drv_cnt % 3 == 0) begin
          dump_valid   = 1'b1;
          prompt_idata = 20'(stim_i(drv_cell, drv_k));
          prompt_qdata = 20'(stim_q(drv_cell, drv_k));
          drv_k++;
        end
      end
    end
  end

  // Scoreboard: every retune must match the next model cell; every done must match the model result.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (chan_restart) begin
        n_restart++;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL restart_extra: unexpected retune to sat %0d freq 0x%0h", satellite_id, carr_frequency);
        end else begin
          cell_t e;
          e = exp_q.pop_front();
          chk("restart_sat", satellite_id, e.sat);
          chk("restart_freq", carr_frequency, e.freq);
          chk("restart_busy", busy, 1);
        end
      end
      if (done) begin
        n_done++;
        chk("done_busy", busy, 0);
        chk("done_found", found, m_found);
        chk("done_found_sat", found_sat, m_sat);
        chk("done_found_bin", found_bin, m_bin);
        chk("done_found_energy", found_energy, m_energy);
        chk("done_cells_left", exp_q.size(), 0);
      end
    end
  end

  task automatic set_cfg(input logic [4:0] sf, input logic [4:0] sl, input logic [29:0] base,
                         input logic [29:0] step, input logic [5:0] nb, input logic [2:0] dw,
                         input logic [14:0] thr);
    c_sat_first = sf; c_sat_last = sl; c_base = base; c_step = step;
    c_bins = nb; c_dwell = dw; c_thr = thr;
    sat_first = sf; sat_last = sl; carr_freq_base = base; carr_freq_step = step;
    num_bins = nb; dwell = dw; acq_threshold = thr;
  endtask

  task automatic set_dumps(input int i0, input int q0, input int i1, input int q1);
    di[0] = i0; dq[0] = q0;
    for (int k = 1; k <= 8; k++) begin di[k] = i1; dq[k] = q1; end
  endtask

  task automatic start_search();
    build_model();
    n_restart = 0; n_done = 0; drv_cell = -1;
    @(negedge wb_clk_i); start = 1'b1;
    @(negedge wb_clk_i); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_restart", chan_restart, 1);
  endtask

  task automatic finish_search(input string nm);
    int cyc;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge wb_clk_i);
      cyc++;
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: no done after %0d cycles, required a done pulse", nm, cyc);
    end
    @(negedge wb_clk_i);
    chk({nm, "_done_count"}, n_done, 1);
    chk({nm, "_restart_count"}, n_restart, m_cells);
    chk({nm, "_hold_sat"}, satellite_id, m_last_sat);
    chk({nm, "_hold_freq"}, carr_frequency, m_last_freq);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_done_width"}, done, 0);
  endtask

  initial begin
    wb_rst_i = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(5'd0, 5'd0, 30'd0, 30'd0, 6'd1, 3'd1, 15'd0);
    set_dumps(0, 0, 0, 0);
    repeat (3) @(negedge wb_clk_i);
    chk("rst_sat", satellite_id, 0);
    chk("rst_freq", carr_frequency, 0);
    chk("rst_restart", chan_restart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_found_energy", found_energy, 0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);

    // Detect on the very first cell: 2 dumps x (1000+1000).
    set_cfg(5'd3, 5'd5, 30'h0ABCDEF, 30'h10, 6'd4, 3'd2, 15'd1);
    set_dumps(1000, -1000, 1000, -1000);
    hit_cell = -1;
    start_search();
    finish_search("first");
    chk("first_found", found, 1);
    chk("first_sat", found_sat, 3);
    chk("first_bin", found_bin, 0);
    chk("first_energy", found_energy, 24'd4000);
    chk("first_restarts", n_restart, 1);

    // Full sweep wrapping 30..1 with a negative step and nothing to find.
    set_cfg(5'd30, 5'd1, 30'h100, 30'h3FFFFFF0, 6'd3, 3'd1, 15'h7FFF);
    set_dumps(0, 0, 0, 0);
    start_search();
    finish_search("sweep");
    chk("sweep_found", found, 0);
    chk("sweep_restarts", n_restart, 12);
    chk("sweep_sat", satellite_id, 1);
    chk("sweep_freq", carr_frequency, 30'hE0);

    // Threshold equality with a huge settle dump: no detection.
    set_cfg(5'd7, 5'd7, 30'h55, 30'h1, 6'd1, 3'd1, 15'd5);
    set_dumps(524287, 524287, 1280, -1280);
    start_search();
    finish_search("thr_eq");
    chk("thr_eq_found", found, 0);

    // One above the threshold: detection.
    set_dumps(524287, 524287, 1281, -1280);
    start_search();
    finish_search("thr_gt");
    chk("thr_gt_found", found, 1);
    chk("thr_gt_energy", found_energy, 24'd2561);

    // Most negative inputs, dwell 0 meaning 8 dumps.
    set_cfg(5'd0, 5'd0, 30'h3FFFFFFF, 30'h1, 6'd0, 3'd0, 15'd1);
    set_dumps(-524288, -524288, -524288, -524288);
    start_search();
    finish_search("extreme");
    chk("extreme_energy", found_energy, 24'h800000);

    // Detection on a later cell, with the carrier word wrapping.
    set_cfg(5'd2, 5'd3, 30'h3FFFFFF8, 30'h10, 6'd2, 3'd3, 15'd1);
    set_dumps(10, 10, 10, 10);
    hit_cell = 3; hit_i = 300; hit_q = -300;
    start_search();
    finish_search("late");
    chk("late_sat", found_sat, 3);
    chk("late_bin", found_bin, 1);
    chk("late_energy", found_energy, 24'd1800);
    chk("late_freq", carr_frequency, 30'h8);

    // Start pulsed during settle with different inputs: the running search is unaffected.
    start_search();
    @(negedge wb_clk_i);
    start = 1'b1; sat_first = 5'd9; num_bins = 6'd1; dwell = 3'd7; acq_threshold = 15'd0;
    @(negedge wb_clk_i);
    start = 1'b0;
    finish_search("busy_start");
    chk("busy_start_sat", found_sat, 3);
    chk("busy_start_bin", found_bin, 1);
    hit_cell = -1;

    // Abort during dwell.
    set_cfg(5'd4, 5'd4, 30'h222, 30'h1, 6'd5, 3'd4, 15'h7FFF);
    set_dumps(50, 50, 50, 50);
    start_search();
    repeat (7) @(negedge wb_clk_i);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_restart", chan_restart, 0);
    repeat (40) @(negedge wb_clk_i);
    chk("abort_no_done", n_done, 0);
    chk("abort_restarts", n_restart, 1);
    chk("abort_hold_sat", satellite_id, 4);
    chk("abort_hold_freq", carr_frequency, 30'h222);
    exp_q.delete();

    // Start and abort together: stays idle.
    n_restart = 0;
    sat_first = 5'd9;
    @(negedge wb_clk_i); start = 1'b1; abort = 1'b1;
    @(negedge wb_clk_i); start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    chk("sa_busy", busy, 0);
    chk("sa_restarts", n_restart, 0);
    chk("sa_sat", satellite_id, 4);

    // Reset mid-dwell.
    set_cfg(5'd6, 5'd6, 30'h1234, 30'h1, 6'd5, 3'd4, 15'h7FFF);
    start_search();
    repeat (7) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    chk("mrst_sat", satellite_id, 0);
    chk("mrst_freq", carr_frequency, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_restart", chan_restart, 0);
    chk("mrst_found", found, 0);
    chk("mrst_found_sat", found_sat, 0);
    chk("mrst_found_bin", found_bin, 0);
    chk("mrst_energy", found_energy, 0);
    repeat (30) @(negedge wb_clk_i);
    chk("mrst_no_done", n_done, 0);
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
